// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD stream controller: FSM states,
// the queued command/data entry and the HD44780 commands that need a long wait.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    WAIT  = 2'd3
  } lcd_state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] value;
  } lcd_entry_t;

  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
  localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

  // Clear and both home encodings take milliseconds inside the panel controller.
  function automatic logic is_long_cmd(input lcd_entry_t ent);
    return !ent.rs && ((ent.value == LCD_CMD_CLEAR) ||
                       (ent.value == LCD_CMD_HOME)  ||
                       (ent.value == LCD_CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_stream_controller_if.sv
// Write-side valid/ready channel carrying one command or data byte per transfer.
interface lcd_stream_controller_if;

  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_byte;

  modport master (
    output wr_valid,
    output wr_rs,
    output wr_byte,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_rs,
    input  wr_byte,
    output wr_ready
  );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// Show-ahead synchronous FIFO of command/data entries with exact occupancy count.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  lcd_entry_t               push_data,
  input  logic                     pop,
  output lcd_entry_t               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);

  lcd_entry_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       level_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (level_reg == LEVEL_FULL);
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign pop_data = mem[rd_ptr_reg];

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign push_ok = push && !full && !rst;
  assign pop_ok  = pop && !empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LEVEL_ONE;
        2'b01:   level_reg <= level_reg - LEVEL_ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == AW'(gi))) mem[gi] <= push_data;
      end
    end
  endgenerate

endmodule

// File: rtl/lcd_stream_controller.sv
// Buffers HD44780 command/data writes and replays them on the panel bus with
// programmable setup, enable-pulse and post-write wait timing (8- or 4-bit bus).
module lcd_stream_controller
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int BUS_4BIT       = 0,
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 23,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic                          clk,
  input  logic                          rst,
  lcd_stream_controller_if.slave        wr,
  output logic [7:0]                    data,
  output logic                          rs,
  output logic                          rw,
  output logic                          e,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int  CLEAR_EFF   = (CLEAR_WAIT_CYC >= 1) ? CLEAR_WAIT_CYC : 1;
  localparam int  MAX_WAIT    = (CLEAR_EFF > CMD_WAIT_CYC) ? CLEAR_EFF : CMD_WAIT_CYC;
  localparam int  MAX_STROBE  = (E_PULSE_CYC > SETUP_CYC) ? E_PULSE_CYC : SETUP_CYC;
  localparam int  MAX_CYC     = (MAX_WAIT > MAX_STROBE) ? MAX_WAIT : MAX_STROBE;
  localparam int  CNT_W       = $clog2(MAX_CYC) + 1;
  localparam bit  NIBBLE_MODE = (BUS_4BIT != 0);

  // Counters are loaded with N-1 and the phase ends on the cycle they read zero.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  lcd_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  lcd_entry_t        entry_reg;
  logic              nibble_lo_reg;
  logic [7:0]        data_reg;
  logic              rs_reg;
  logic              e_reg;

  lcd_entry_t        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign wr.wr_ready = !fifo_full && !rst;
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = (state_reg == IDLE) && !fifo_empty && !rst;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{rs: wr.wr_rs, value: wr.wr_byte}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      entry_reg     <= '0;
      nibble_lo_reg <= 1'b0;
      data_reg      <= 8'h00;
      rs_reg        <= 1'b0;
      e_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            entry_reg     <= head;
            rs_reg        <= head.rs;
            data_reg      <= NIBBLE_MODE ? {head.value[7:4], 4'h0} : head.value;
            nibble_lo_reg <= 1'b0;
            cnt_reg       <= SETUP_LOAD;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_reg == '0) begin
            e_reg     <= 1'b1;
            cnt_reg   <= PULSE_LOAD;
            state_reg <= PULSE;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        PULSE: begin
          if (cnt_reg == '0) begin
            e_reg     <= 1'b0;
            state_reg <= WAIT;
            // The long clear/home wait only follows the final (or only) transfer.
            if (NIBBLE_MODE && !nibble_lo_reg)  cnt_reg <= CMD_LOAD;
            else if (is_long_cmd(entry_reg))    cnt_reg <= CLEAR_LOAD;
            else                                cnt_reg <= CMD_LOAD;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            if (NIBBLE_MODE && !nibble_lo_reg) begin
              data_reg      <= {entry_reg.value[3:0], 4'h0};
              nibble_lo_reg <= 1'b1;
              cnt_reg       <= SETUP_LOAD;
              state_reg     <= SETUP;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data = data_reg;
  assign rs   = rs_reg;
  assign rw   = 1'b0;
  assign e    = e_reg;
  assign busy = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lcd_stream_controller.sv
// Drives an 8-bit and a 4-bit controller with the same writes and compares every
// cycle against a timeline of loads and enable pulses computed from the timing rules.
module tb_lcd_stream_controller;

  localparam int S    = 2;
  localparam int E    = 3;
  localparam int CMD  = 5;
  localparam int CLR  = 20;
  localparam int D    = 4;
  localparam int MAXC = 4096;
  localparam int QN   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_byte;

  lcd_stream_controller_if if8 ();
  lcd_stream_controller_if if4 ();

  logic [7:0] data8, data4;
  logic       rs8, rs4, rw8, rw4, e8, e4, busy8, busy4;
  logic [2:0] lvl8, lvl4;

  assign if8.wr_valid = in_valid;
  assign if8.wr_rs    = in_rs;
  assign if8.wr_byte  = in_byte;
  assign if4.wr_valid = in_valid;
  assign if4.wr_rs    = in_rs;
  assign if4.wr_byte  = in_byte;

  lcd_stream_controller #(
    .FIFO_DEPTH(D), .BUS_4BIT(0), .SETUP_CYC(S), .E_PULSE_CYC(E),
    .CMD_WAIT_CYC(CMD), .CLEAR_WAIT_CYC(CLR)
  ) dut8 (
    .clk(clk), .rst(rst), .wr(if8), .data(data8), .rs(rs8), .rw(rw8),
    .e(e8), .busy(busy8), .fifo_level(lvl8)
  );

  lcd_stream_controller #(
    .FIFO_DEPTH(D), .BUS_4BIT(1), .SETUP_CYC(S), .E_PULSE_CYC(E),
    .CMD_WAIT_CYC(CMD), .CLEAR_WAIT_CYC(CLR)
  ) dut4 (
    .clk(clk), .rst(rst), .wr(if4), .data(data4), .rs(rs4), .rw(rw4),
    .e(e4), .busy(busy4), .fifo_level(lvl4)
  );

  // Reference timeline per instance (0 = 8-bit, 1 = 4-bit), indexed by edge number.
  bit         exp_e [2][MAXC];
  bit         ld_v  [2][MAXC];
  logic [7:0] ld_d  [2][MAXC];
  bit         ld_rs [2][MAXC];
  logic [8:0] mq    [2][QN];
  int         qh [2];
  int         qt [2];
  int         qn [2];
  int         avail [2];
  logic [7:0] mdata [2];
  bit         mrs [2];
  int         cyc;
  int         n_vec;
  int         n_err;

  task automatic check_val(input string tag, input int m, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s[bus%0d] cycle %0d: got %0h expected %0h",
               tag, (m == 0) ? 8 : 4, cyc, obs, exp);
    end
  endtask

  task automatic put_load(input int m, input int t, input logic [7:0] d, input bit r);
    if (t < MAXC) begin
      ld_v[m][t]  = 1'b1;
      ld_d[m][t]  = d;
      ld_rs[m][t] = r;
    end
  endtask

  task automatic put_pulse(input int m, input int t);
    for (int k = t; k < t + E; k++)
      if (k < MAXC) exp_e[m][k] = 1'b1;
  endtask

  // An entry popped at edge c: data appears at c, e high from c+S for E edges,
  // then the wait; the next pop may happen one edge after the wait ends.
  task automatic schedule(input int m, input int c, input logic [8:0] ent);
    bit         r;
    logic [7:0] b;
    int         w;
    int         t;
    r = ent[8];
    b = ent[7:0];
    w = (!r && (b == 8'h01 || b == 8'h02 || b == 8'h03)) ? CLR : CMD;
    if (m == 0) begin
      put_load(m, c, b, r);
      put_pulse(m, c + S);
      avail[m] = c + S + E + w + 1;
    end else begin
      put_load(m, c, {b[7:4], 4'h0}, r);
      put_pulse(m, c + S);
      t = c + S + E + CMD;
      put_load(m, t, {b[3:0], 4'h0}, r);
      put_pulse(m, t + S);
      avail[m] = t + S + E + w + 1;
    end
  endtask

  task automatic model_edge(input int m);
    int  c;
    bit  acc;
    c = cyc;
    if (rst) begin
      qh[m] = 0; qt[m] = 0; qn[m] = 0; avail[m] = 0;
      for (int k = c; k < MAXC; k++) begin
        exp_e[m][k] = 1'b0;
        ld_v[m][k]  = 1'b0;
      end
      mdata[m] = 8'h00;
      mrs[m]   = 1'b0;
    end else begin
      acc = in_valid && (qn[m] < D);
      if (c >= avail[m] && qn[m] > 0) begin
        schedule(m, c, mq[m][qh[m]]);
        qh[m] = (qh[m] + 1) % QN;
        qn[m]--;
      end
      if (acc) begin
        mq[m][qt[m]] = {in_rs, in_byte};
        qt[m] = (qt[m] + 1) % QN;
        qn[m]++;
      end
      if (c < MAXC && ld_v[m][c]) begin
        mdata[m] = ld_d[m][c];
        mrs[m]   = ld_rs[m][c];
      end
    end
  endtask

  task automatic check_outputs(input int m);
    bit eexp;
    bit bexp;
    eexp = (cyc < MAXC) ? exp_e[m][cyc] : 1'b0;
    bexp = (qn[m] > 0) || (cyc < avail[m] - 1);
    check_val("e",          m, 32'(m == 0 ? e8    : e4),    32'(eexp));
    check_val("data",       m, 32'(m == 0 ? data8 : data4), 32'(mdata[m]));
    check_val("rs",         m, 32'(m == 0 ? rs8   : rs4),   32'(mrs[m]));
    check_val("rw",         m, 32'(m == 0 ? rw8   : rw4),   32'(0));
    check_val("busy",       m, 32'(m == 0 ? busy8 : busy4), 32'(bexp));
    check_val("fifo_level", m, 32'(m == 0 ? lvl8  : lvl4),  32'(qn[m]));
    check_val("wr_ready",   m, 32'(m == 0 ? if8.wr_ready : if4.wr_ready),
              32'(!rst && (qn[m] < D)));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic push_one(input bit r, input logic [7:0] b);
    in_valid = 1'b1;
    in_rs    = r;
    in_byte  = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((qn[0] > 0 || qn[1] > 0 || cyc < avail[0] || cyc < avail[1]) && g < 2000) begin
      step();
      g++;
    end
    step();
    step();
    check_val("drain_timeout", 0, 32'(g >= 2000), 32'(0));
  endtask

  initial begin
    int k;
    cyc      = 0;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_rs    = 1'b0;
    in_byte  = 8'h00;
    for (int m = 0; m < 2; m++) begin
      qh[m] = 0; qt[m] = 0; qn[m] = 0; avail[m] = 0;
      mdata[m] = 8'h00; mrs[m] = 1'b0;
    end

    step();
    step();
    rst = 1'b0;
    step();

    push_one(1'b0, 8'h01);
    drain();
    push_one(1'b1, 8'h20);
    drain();
    push_one(1'b1, 8'h41);
    drain();

    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_rs    = 1'b1;
      in_byte  = 8'h30 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Abort a transfer while the enable strobe is high.
    push_one(1'b1, 8'h55);
    k = 0;
    while (!e8 && k < 20) begin
      step();
      k++;
    end
    check_val("e_rise_timeout", 0, 32'(k >= 20), 32'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (30) step();

    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_rs    = 1'($urandom_range(0, 1));
      in_byte  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
